// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the instruction/data memory port arbiter:
// access width codes, FSM state encoding, grant encoding and the
// legality check for data-port requests.
package mem_port_arbiter_pkg;

  // Data access width codes as presented on d_width (2'b11 is illegal)
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic {
    G_I = 1'b0,
    G_D = 1'b1
  } grant_t;

  // A data request is illegal for an unknown width or a misaligned half/word.
  function automatic logic d_illegal(input logic [1:0] width, input logic [1:0] off);
    logic bad;
    case (width)
      W_BYTE:  bad = 1'b0;
      W_HALF:  bad = off[0];
      W_WORD:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// External single-ported memory bus.
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata : driven by the arbiter (master)
//   mem_ready/mem_rdata                          : driven by the memory (slave)
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// mem_port_arbiter_lane_align
// Combinational byte-lane alignment for a 32-bit little-endian bus.
//   width/ext/off : access width code, zero-extend flag, byte offset addr[1:0]
//   wdata         : right-justified store data
//   rdata         : raw bus read word
//   wstrb         : byte enables for a store
//   wdata_lane    : store data replicated and moved onto its lanes
//   rdata_ext     : load data extracted from its lanes and extended
module mem_port_arbiter_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        ext,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt;
  logic [31:0] rsh;

  assign shamt = {off, 3'b000};
  assign rsh   = rdata >> shamt;

  always_comb begin
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (width)
      W_BYTE: begin
        wstrb      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}} << shamt;
        rdata_ext  = ext ? {24'd0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
      end
      W_HALF: begin
        wstrb      = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}} << shamt;
        rdata_ext  = ext ? {16'd0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter sharing one external memory bus between the fetch
// port (i_*) and the data port (d_*). Each transfer runs IDLE -> BUS -> RESP;
// the winner gets a one-cycle valid pulse, with err on illegal access or
// bus timeout.
//   clk, rst         : clock, synchronous active-high reset
//   i_req/i_addr     : fetch request (level) and word address
//   i_valid/i_rdata  : fetch completion pulse and fetched word
//   d_r_req/d_w_req  : load/store request (level; both high = store)
//   d_ext/d_width    : zero-extend flag, access width
//   d_addr/d_wdata   : byte address, right-justified store data
//   d_valid/d_rdata  : data completion pulse and extended load data
//   err              : failure flag accompanying a valid pulse
//   bus              : external memory bus (master side)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT       = 0,
  parameter bit RESET_FAVOR_D = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_r_req,
  input  logic        d_w_req,
  input  logic        d_ext,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        err,
  mem_port_arbiter_if.master bus
);

  localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      state_reg, state_next;
  grant_t      grant_reg, last_grant_reg, grant_pick;
  logic [31:0] addr_reg, wdata_reg, rdata_reg, tmo_cnt_reg;
  logic [1:0]  width_reg;
  logic        we_reg, ext_reg, err_reg;

  logic        d_req, any_req, pick_illegal, handshake, timeout_hit;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata, lane_rdata;

  assign d_req   = d_r_req | d_w_req;
  assign any_req = i_req | d_req;

  // On a contest the port that did not win last time goes first.
  always_comb begin
    if (i_req && d_req)
      grant_pick = (last_grant_reg == G_I) ? G_D : G_I;
    else
      grant_pick = d_req ? G_D : G_I;
  end

  assign pick_illegal = (grant_pick == G_D) && d_illegal(d_width, d_addr[1:0]);
  assign handshake    = (state_reg == BUS) && bus.mem_ready;
  // The last counted cycle still accepts mem_ready; only then do we give up.
  assign timeout_hit  = (TIMEOUT > 0) && (state_reg == BUS) && !bus.mem_ready &&
                        (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = pick_illegal ? RESP : BUS;
      BUS:     if (handshake || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are latched at grant so later changes by the core are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg      <= G_I;
      last_grant_reg <= RESET_FAVOR_D ? G_I : G_D;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      tmo_cnt_reg    <= '0;
      width_reg      <= W_WORD;
      we_reg         <= 1'b0;
      ext_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (any_req) begin
          grant_reg      <= grant_pick;
          last_grant_reg <= grant_pick;
          err_reg        <= pick_illegal;
          rdata_reg      <= '0;
          tmo_cnt_reg    <= '0;
          if (grant_pick == G_D) begin
            addr_reg  <= d_addr;
            we_reg    <= d_w_req;
            width_reg <= d_width;
            ext_reg   <= d_ext;
            wdata_reg <= d_wdata;
          end else begin
            addr_reg  <= i_addr;
            we_reg    <= 1'b0;
            width_reg <= W_WORD;
            ext_reg   <= 1'b0;
            wdata_reg <= '0;
          end
        end
        BUS: begin
          if (handshake)        rdata_reg   <= bus.mem_rdata;
          else if (timeout_hit) err_reg     <= 1'b1;
          else                  tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
        end
        default: ;
      endcase
    end
  end

  mem_port_arbiter_lane_align u_lane_align (
    .width      (width_reg),
    .ext        (ext_reg),
    .off        (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .rdata      (rdata_reg),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  // Bus fields are forced to zero outside BUS so the bus is quiet when idle.
  always_comb begin
    bus.mem_req   = (state_reg == BUS);
    bus.mem_we    = bus.mem_req && we_reg;
    bus.mem_addr  = bus.mem_req ? {addr_reg[31:2], 2'b00} : 32'd0;
    bus.mem_wstrb = bus.mem_we ? lane_strb : 4'd0;
    bus.mem_wdata = bus.mem_we ? lane_wdata : 32'd0;
    i_valid       = (state_reg == RESP) && (grant_reg == G_I);
    d_valid       = (state_reg == RESP) && (grant_reg == G_D);
    err           = (state_reg == RESP) && err_reg;
    i_rdata       = (i_valid && !err_reg) ? rdata_reg : 32'd0;
    d_rdata       = (d_valid && !err_reg && !we_reg) ? lane_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (TIMEOUT=4, RESET_FAVOR_D=1).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_r_req, d_w_req, d_ext;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_width;
  logic        i_valid, d_valid, err;
  logic [31:0] i_rdata, d_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(4), .RESET_FAVOR_D(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_valid (i_valid),
    .i_rdata (i_rdata),
    .d_r_req (d_r_req),
    .d_w_req (d_w_req),
    .d_ext   (d_ext),
    .d_width (d_width),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drop_all();
    i_req = 1'b0; d_r_req = 1'b0; d_w_req = 1'b0;
  endtask

  // Single load with immediate ready: BUS cycle, then RESP cycle.
  task automatic do_load(input string tag, input logic [31:0] addr,
                         input logic [1:0] width, input logic ext,
                         input logic [31:0] exp);
    d_r_req = 1'b1; d_addr = addr; d_width = width; d_ext = ext;
    tick();
    tick();
    check({tag, " d_valid"}, {31'd0, d_valid}, 32'd1);
    check({tag, " d_rdata"}, d_rdata, exp);
    drop_all();
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b0;
    drop_all();
    d_ext = 1'b0; d_width = W_WORD;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '0;

    // Reset state
    do_reset();
    check("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst valids/err", {29'd0, i_valid, d_valid, err}, 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);

    // Single fetch with immediate ready
    bus.mem_rdata = 32'h00500093;
    i_req = 1'b1; i_addr = 32'h00400000;
    tick();
    check("fetch mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("fetch mem_addr", bus.mem_addr, 32'h00400000);
    check("fetch mem_wstrb/we", {27'd0, bus.mem_we, bus.mem_wstrb}, 32'd0);
    check("fetch early valid", {31'd0, i_valid}, 32'd0);
    tick();
    check("fetch i_valid", {31'd0, i_valid}, 32'd1);
    check("fetch i_rdata", i_rdata, 32'h00500093);
    check("fetch err", {31'd0, err}, 32'd0);
    drop_all();
    tick();
    check("fetch pulse width", {30'd0, i_valid, bus.mem_req}, 32'd0);

    // Contest after reset: D first; D re-requests at once so I wins next.
    do_reset();
    bus.mem_rdata = 32'h11223344;
    i_req = 1'b1; d_r_req = 1'b1; d_addr = 32'h00000020; d_width = W_WORD;
    tick();
    check("contest1 grant D", bus.mem_addr, 32'h00000020);
    tick();
    check("contest1 d_valid", {30'd0, i_valid, d_valid}, 32'd1);
    check("contest1 d_rdata", d_rdata, 32'h11223344);
    d_addr = 32'h00000024;
    tick();
    tick();
    check("contest2 grant I", bus.mem_addr, 32'h00400000);
    tick();
    check("contest2 i_valid", {30'd0, i_valid, d_valid}, 32'd2);
    i_req = 1'b0;
    tick();
    tick();
    check("contest2 D next", bus.mem_addr, 32'h00000024);
    tick();
    check("contest2 d_valid", {31'd0, d_valid}, 32'd1);
    drop_all();
    tick();

    // Store byte at offset 3
    d_w_req = 1'b1; d_addr = 32'h10010003; d_width = W_BYTE; d_wdata = 32'h000000AB;
    tick();
    check("sb mem_addr", bus.mem_addr, 32'h10010000);
    check("sb wstrb/we", {27'd0, bus.mem_we, bus.mem_wstrb}, 32'h18);
    check("sb wdata lane3", {24'd0, bus.mem_wdata[31:24]}, 32'hAB);
    tick();
    check("sb d_valid/err", {30'd0, d_valid, err}, 32'd2);
    drop_all();
    tick();

    // Store half at offset 2, with d_r_req also high (treated as store)
    d_w_req = 1'b1; d_r_req = 1'b1; d_addr = 32'h10010002; d_width = W_HALF;
    d_wdata = 32'h1234CDEF;
    tick();
    check("sh wstrb/we", {27'd0, bus.mem_we, bus.mem_wstrb}, 32'h1C);
    check("sh wdata upper", {16'd0, bus.mem_wdata[31:16]}, 32'hCDEF);
    tick();
    drop_all();
    tick();

    // Load lane extraction and extension
    bus.mem_rdata = 32'h80FF7F01;
    do_load("lb off2",  32'h10000002, W_BYTE, 1'b0, 32'hFFFFFFFF);
    do_load("lbu off2", 32'h10000002, W_BYTE, 1'b1, 32'h000000FF);
    do_load("lb off1",  32'h10000001, W_BYTE, 1'b0, 32'h0000007F);
    do_load("lh off2",  32'h10000002, W_HALF, 1'b0, 32'hFFFF80FF);
    do_load("lhu off0", 32'h10000000, W_HALF, 1'b1, 32'h00007F01);
    do_load("lw",       32'h10000000, W_WORD, 1'b0, 32'h80FF7F01);

    // Misaligned word load: straight to RESP with err, no bus activity
    d_r_req = 1'b1; d_addr = 32'h10000002; d_width = W_WORD;
    tick();
    check("misalign mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("misalign valid/err", {30'd0, d_valid, err}, 32'd3);
    check("misalign d_rdata", d_rdata, 32'd0);
    drop_all();
    tick();

    // Illegal width code 11
    d_w_req = 1'b1; d_addr = 32'h10000000; d_width = 2'b11;
    tick();
    check("w11 no write", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    check("w11 valid/err", {30'd0, d_valid, err}, 32'd3);
    drop_all();
    tick();

    // Timeout: mem_ready stuck low
    bus.mem_ready = 1'b0;
    d_r_req = 1'b1; d_addr = 32'h00000040; d_width = W_WORD;
    n = 0;
    tick();
    while (bus.mem_req && n < 20) begin
      n++;
      tick();
    end
    check("timeout req cycles", n, 32'd4);
    check("timeout valid/err", {30'd0, d_valid, err}, 32'd3);
    check("timeout d_rdata", d_rdata, 32'd0);
    drop_all();
    tick();

    // Ready arriving on the last allowed cycle still completes normally
    bus.mem_rdata = 32'hCAFEF00D;
    d_r_req = 1'b1; d_addr = 32'h00000044;
    tick(); tick(); tick(); tick();
    check("late ready still bus", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ready = 1'b1;
    tick();
    check("late ready valid/err", {30'd0, d_valid, err}, 32'd2);
    check("late ready d_rdata", d_rdata, 32'hCAFEF00D);
    drop_all();
    tick();

    // Reset while in BUS
    bus.mem_ready = 1'b0;
    i_req = 1'b1;
    tick();
    check("midrst mem_req before", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    check("midrst mem_req dropped", {31'd0, bus.mem_req}, 32'd0);
    check("midrst no pulse", {29'd0, i_valid, d_valid, err}, 32'd0);
    rst = 1'b0; i_req = 1'b0; bus.mem_ready = 1'b1;
    tick();
    check("midrst still quiet", {30'd0, i_valid, bus.mem_req}, 32'd0);
    i_req = 1'b1; d_r_req = 1'b1; d_addr = 32'h00000080; d_width = W_WORD;
    tick();
    check("midrst contest D", bus.mem_addr, 32'h00000080);
    tick();
    check("midrst d_valid", {30'd0, i_valid, d_valid}, 32'd1);
    drop_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported external memory bus between the core's instruction-fetch port and data-access port.
- Arbitrates round-robin, sequences each transfer through a req/ready handshake, and returns a one-cycle valid pulse to the winner.
- Performs byte-lane alignment: store strobes and data shifting, and load extraction with sign/zero extension.
- Sits between the core's icache_*/dcache_* ports and the memory/bus model.

Parameters:
- TIMEOUT, 0: cycles to wait for mem_ready before aborting with an error; 0 disables the timeout.
- RESET_FAVOR_D, 1: 1 = data port wins the first simultaneous contest after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; level, held until i_valid
- i_addr  in  32  fetch address; word aligned, bits [1:0] ignored
- i_valid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  32  fetched word
- d_r_req  in  1  load request; level, held until d_valid
- d_w_req  in  1  store request; level, held until d_valid
- d_ext  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
- d_width  in  2  00 byte, 01 half, 10 word; 11 is illegal
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-justified
- d_valid  out  1  one-cycle pulse; load data valid or store done
- d_rdata  out  32  extended load data
- err  out  1  one-cycle pulse together with i_valid/d_valid when the access failed
- mem_req  out  1  bus request; held until mem_ready
- mem_we  out  1  write
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ready  in  1  transfer completes on a cycle where mem_req & mem_ready
- mem_rdata  in  32  read word, valid with mem_ready

Behaviour:
- Reset (clk edge with rst=1):
  - All outputs go to 0; FSM goes to IDLE.
  - last_grant = I if RESET_FAVOR_D=1, else D.
  - Timeout counter clears.
  - A reset mid-transfer drops mem_req on the next cycle; no valid/err pulse is ever produced for the aborted request.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Sample requests; a D request is d_r_req | d_w_req.
  - If both ports request, grant the port not equal to last_grant; otherwise grant the sole requester.
  - Latch addr, we, width, ext and wdata; update last_grant; go to BUS.
- Illegal D request, checked in IDLE: d_width=11, or misaligned (half with addr[0]=1, word with addr[1:0]≠0).
  - The request never reaches the bus; go directly to RESP with err=1.
  - d_rdata = 0; no memory write occurs.
- BUS:
  - mem_req=1 with the latched fields, stable until handshake.
  - On mem_req & mem_ready: capture mem_rdata and go to RESP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without mem_ready: go to RESP with err=1 and drop mem_req.
- RESP:
  - Pulse the winner's valid (and err if set) for one cycle; return to IDLE.
  - A requester must deassert, or present its next request, in the cycle after its valid; the arbiter samples again in IDLE on the following cycle.
  - So the loser of a contest is served in the very next IDLE.
- Minimum latency: request sampled at edge N; mem_req high during cycle N+1; with immediate ready, valid is high in cycle N+2. One bus transfer per 3 cycles maximum.
- Byte-lane rules, off = addr[1:0]:
  - Store strobes: byte 0001<<off; half 0011<<off; word 1111.
  - mem_wdata = d_wdata replicated per width and shifted by 8*off.
  - Load: byte = rdata[8*off+:8]; half = rdata[8*off+:16]; word = rdata.
  - Extension: zero if d_ext=1, sign otherwise.
  - Fetch reads use mem_wstrb=0.
- d_r_req and d_w_req both high: treated as a store.
- Changing request fields while waiting: no effect, since fields are latched at grant.

Decomposition:
- mem_pkg:
  - Width codes (W_BYTE/W_HALF/W_WORD).
  - FSM state encoding (IDLE/BUS/RESP).
  - Grant encoding (G_I/G_D).
- One natural sub-module, lane_align:
  - Combinational strobe/wdata shift and load extract/extend.
  - Reusable by a future dcache.

Test Plan:
- Single fetch: i_req=1, i_addr=0x00400000, mem_ready tied 1, mem_rdata=0x00500093 -> mem_req high the cycle after sampling; i_valid pulses 2 cycles after sampling with i_rdata=0x00500093; err=0.
- Contest after reset: i_req and d_r_req rise together -> D granted first, I served in the next IDLE; then a second simultaneous contest -> I first (round-robin alternates).
- Store byte: d_w_req, d_addr=0x10010003, d_width=00, d_wdata=0x000000AB -> mem_addr=0x10010000, mem_wstrb=1000, mem_wdata[31:24]=0xAB, mem_we=1.
- Load lanes: mem_rdata=0x80FF7F01 -> LB at offset 2 gives 0xFFFFFFFF; LBU at offset 2 gives 0x000000FF; LH at offset 2 gives 0xFFFF80FF; LHU at offset 0 gives 0x00007F01.
- Misaligned and timeout: LW at 0x...2 -> no mem_req, d_valid+err with d_rdata=0. With TIMEOUT=4 and mem_ready stuck 0 -> mem_req high exactly 4 cycles, then d_valid+err.
- Reset mid-BUS: assert rst while mem_req=1 -> mem_req=0 the next cycle; no i_valid/d_valid; the first post-reset contest is again won by D.
